// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane writes acked next cycle, reads acked RD_LAT cycles after accept.
// Requests are accepted only while busy is low; anything arriving during a read is dropped.
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] last_store
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] LAT_INIT = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        lat_cnt, lat_nxt;
  logic [ADDR_W-1:0] rd_idx, rd_idx_nxt;
  logic              rd_oor, rd_oor_nxt;
  logic              busy_nxt, ack_nxt, err_nxt;
  logic [31:0]       douta_nxt, store_nxt;
  logic              mem_we;

  logic [31:0]       mem [DEPTH];

  logic              in_range;
  logic [ADDR_W-1:0] index;
  logic [31:0]       cur_word, rd_word, merged;

  assign in_range = (addr[31:ADDR_W] == '0);
  assign index    = addr[ADDR_W-1:0];
  assign cur_word = mem[index];
  assign rd_word  = mem[rd_idx];

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) merged[8*i +: 8] = dina[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt  = state;
    lat_nxt    = lat_cnt;
    rd_idx_nxt = rd_idx;
    rd_oor_nxt = rd_oor;
    busy_nxt   = busy;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;
    douta_nxt  = douta;
    store_nxt  = last_store;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (we != 4'h0) begin
            ack_nxt = 1'b1;
            err_nxt = !in_range;
            if (in_range) begin
              mem_we    = 1'b1;
              store_nxt = merged;
            end
          end else if (RD_LAT == 1) begin
            ack_nxt   = 1'b1;
            err_nxt   = !in_range;
            douta_nxt = in_range ? cur_word : 32'h0;
          end else begin
            state_nxt  = RD_WAIT;
            busy_nxt   = 1'b1;
            lat_nxt    = LAT_INIT;
            rd_idx_nxt = index;
            rd_oor_nxt = !in_range;
          end
        end
      end
      RD_WAIT: begin
        // Memory cannot change while busy, so sampling at the final edge is safe.
        if (lat_cnt == 2'd0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          ack_nxt   = 1'b1;
          err_nxt   = rd_oor;
          douta_nxt = rd_oor ? 32'h0 : rd_word;
        end else begin
          lat_nxt = lat_cnt - 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      rd_idx     <= '0;
      rd_oor     <= 1'b0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      douta      <= 32'h0;
      last_store <= 32'h0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_nxt;
      rd_idx     <= rd_idx_nxt;
      rd_oor     <= rd_oor_nxt;
      busy       <= busy_nxt;
      ack        <= ack_nxt;
      err        <= err_nxt;
      douta      <= douta_nxt;
      last_store <= store_nxt;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[index] <= merged;
  end

endmodule
